cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/breakpoint sequencer for the pipelined CPU on the board top level.
//  Replaces the free-running divided clock with a single-cycle clock enable
//  (cpu_ce) on clk_in, giving free-run, single-step and PC-breakpoint modes.
//  Status outputs (state_o, halted, step_cnt) are intended for the seg7 display mux.
// PARAMETERS
//  DIV_W  20  free-run period = 2**DIV_W clk_in cycles; legal range 2..31
//  DB_W   16  debounce window = 2**DB_W-1 stable cycles on run_sw / step_btn
// PORTS
//  clk_in     in   1   system clock; all logic is posedge
//  reset      in   1   asynchronous, active-high
//  run_sw     in   1   raw switch, 1 = free-run request
//  step_btn   in   1   raw pushbutton, rising edge = one step request
//  cpu_stall  in   1   hold request; no cpu_ce while high
//  bp_en      in   1   breakpoint enable
//  bp_addr    in   32  breakpoint PC
//  cpu_pc     in   32  CPU current PC (top_pc)
//  cpu_ce     out  1   one-cycle CPU clock enable
//  halted     out  1   1 while in BREAK
//  state_o    out  2   IDLE=00 RUN=01 STEP=10 BREAK=11
//  step_cnt   out  32  number of cpu_ce pulses issued
// BEHAVIOUR
//  - Reset: state IDLE; cpu_ce=0, halted=0, step_cnt=0; divider, debounce
//    counters, synchronisers and bp_chk all 0.
//  - run_sw, step_btn: 2-FF synchroniser, then debounce. Counter clears on
//    any change of the synced input; the debounced value updates when the
//    counter reaches 2**DB_W-1. step_req = 1-cycle pulse on debounced 0->1.
//  - Divider div_cnt (DIV_W bits) free-runs in all states and wraps;
//    tick = (div_cnt == all-ones).
//  - cpu_ce is combinational from registered state:
//      RUN  & tick      & !cpu_stall
//      STEP & !cpu_stall
//    It is never high in IDLE or BREAK.
//  - A tick during a stall is dropped, not deferred. A STEP pulse waits
//    through the stall.
//  - Transitions (evaluated every cycle, first match wins):
//      IDLE : run_db=1 -> RUN; else step_req -> STEP
//             (run and step in the same cycle: run wins, step dropped)
//      RUN  : run_db=0 -> IDLE; bp_chk & bp_en & cpu_pc==bp_addr -> BREAK;
//             step_req ignored
//      STEP : cpu_ce=1 -> IDLE (exactly one pulse per request)
//      BREAK: run_db=0 -> IDLE; step_req -> STEP
//  - bp_chk is a register: set to 1 the cycle after cpu_ce in RUN, else 0.
//    The compare therefore uses the PC after the CPU has advanced.
//    Timing: cpu_ce at cycle t -> compare at t+1 -> state=BREAK, halted=1
//    at t+2.
//  - Breakpoints are checked only after a RUN pulse. Re-entering RUN while
//    the PC equals bp_addr issues the next pulse normally. Steps from BREAK
//    never re-trigger BREAK.
//  - step_req while in STEP is dropped. Steps do not queue.
//  - halted = (state==BREAK); state_o = state, registered.
//  - Reset mid-pulse: cpu_ce drops immediately (async), and any pending
//    step is discarded.
// CONFIGURATION
//  STEP_COUNT_EN defined:
//    step_cnt increments by 1 on every cpu_ce cycle and wraps
//    0xFFFFFFFF -> 0.
//  STEP_COUNT_EN undefined:
//    step_cnt is tied to 32'h0 and no counter flops are built.
// TESTING (DIV_W=4, DB_W=3 for simulation)
//  1 Reset asserted mid-RUN -> cpu_ce=0, state_o=00, halted=0 at once;
//    after release, IDLE with no pulses.
//  2 run_sw=1 held -> state_o=01 after sync+debounce; cpu_ce high exactly
//    1 cycle in every 16; run_sw=0 -> IDLE, pulses stop.
//  3 step_btn bounces 0/1 for 5 cycles, then held 1 for 20 -> exactly one
//    cpu_ce, state returns to 00. Bounce shorter than 7 cycles -> 0 pulses.
//  4 bp_en=1, bp_addr=0x0000_0010, model PC += 4 per cpu_ce from 0 ->
//    halted=1 and state_o=11 two cycles after the 4th pulse; no further
//    pulses. A step then gives exactly 1 pulse (PC 0x14) and state 00.
//  5 STEP request with cpu_stall=1 for 10 cycles -> no cpu_ce during the
//    stall; one pulse on the first cycle after stall drops. RUN tick under
//    stall -> pulse lost, the next one 16 cycles later.
//  6 STEP_COUNT_EN: 40 RUN pulses -> step_cnt=40. Force count to
//    0xFFFF_FFFF, one more pulse -> 0. Without the macro, step_cnt stays 0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer producing a one-cycle CPU clock enable; state outputs are registered,
// cpu_ce is combinational from state, and cpu_stall holds it low. Optional step counter via STEP_COUNT_EN.
module cpu_run_ctrl #(
    parameter int DIV_W = 20,
    parameter int DB_W  = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        cpu_stall,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] cpu_pc,
    output logic        cpu_ce,
    output logic        halted,
    output logic [1:0]  state_o,
    output logic [31:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] DB_MAX = '1;

    state_t            state_q, state_d;
    logic [1:0]        sync1, sync2, sync_d, db;
    logic [1:0][DB_W-1:0] db_cnt;
    logic              step_db_d;
    logic [DIV_W-1:0]  div_cnt;
    logic              bp_chk;
    logic              run_db, step_req, tick;

    // Bit 0 is run_sw, bit 1 is step_btn; each debounce counter restarts on any synced edge
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_d    <= '0;
            db        <= '0;
            db_cnt    <= '0;
            step_db_d <= 1'b0;
        end else begin
            sync1     <= {step_btn, run_sw};
            sync2     <= sync1;
            sync_d    <= sync2;
            step_db_d <= db[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != sync_d[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] == DB_MAX)
                    db[i] <= sync2[i];
                else
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
        end
    end

    assign run_db   = db[0];
    assign step_req = db[1] & ~step_db_d;
    assign tick     = &div_cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_cnt <= '0;
            bp_chk  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_cnt <= div_cnt + DIV_W'(1);
            bp_chk  <= (state_q == RUN) && cpu_ce;
        end
    end

    // bp_chk lags a RUN pulse by one cycle so the compare sees the advanced PC
    always_comb begin
        state_d = state_q;
        cpu_ce  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_db)
                    state_d = RUN;
                else if (step_req)
                    state_d = STEP;
            end
            RUN: begin
                cpu_ce = tick & ~cpu_stall;
                if (!run_db)
                    state_d = IDLE;
                else if (bp_chk && bp_en && (cpu_pc == bp_addr))
                    state_d = BRK;
            end
            STEP: begin
                cpu_ce = ~cpu_stall;
                if (cpu_ce)
                    state_d = IDLE;
            end
            BRK: begin
                if (!run_db)
                    state_d = IDLE;
                else if (step_req)
                    state_d = STEP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign halted  = (state_q == BRK);
    assign state_o = state_q;

`ifdef STEP_COUNT_EN
    logic [31:0] step_cnt_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            step_cnt_q <= '0;
        else if (cpu_ce)
            step_cnt_q <= step_cnt_q + 32'd1;
    end

    assign step_cnt = step_cnt_q;
`else
    assign step_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV_W=4 (tick every 16 cycles) and DB_W=3 (debounce 7 cycles).
module tb_cpu_run_ctrl;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        cpu_stall = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] cpu_pc;
    logic        cpu_ce;
    logic        halted;
    logic [1:0]  state_o;
    logic [31:0] step_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    cpu_run_ctrl #(.DIV_W(4), .DB_W(3)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .cpu_stall (cpu_stall),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .cpu_pc    (cpu_pc),
        .cpu_ce    (cpu_ce),
        .halted    (halted),
        .state_o   (state_o),
        .step_cnt  (step_cnt)
    );

    always #5 clk_in = ~clk_in;

    // CPU model: PC advances by 4 on every enabled cycle
    always @(posedge clk_in or posedge reset) begin
        if (reset)
            cpu_pc <= 32'h0;
        else if (cpu_ce)
            cpu_pc <= cpu_pc + 32'd4;
    end

    always @(posedge clk_in) begin
        if (!reset && cpu_ce)
            pulses <= pulses + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_pulses(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (pulses < target && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk(name, 32'(pulses), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset = 1'b1;
        run_sw = 1'b0;
        step_btn = 1'b0;
        cpu_stall = 1'b0;
        bp_en = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       run;
        logic       step;
        logic       stall;
        int         cycles;
        logic [1:0] exp_state;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int base;
        int n;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 20, 2'b00, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 12, 2'b01, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32, 2'b01, 2};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16, 2'b01, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16, 2'b01, 1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 12, 2'b00, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 10, 2'b00, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 13, 2'b00, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 20, 2'b00, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 12, 2'b00, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 13, 2'b10, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 10, 2'b10, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1,  2'b00, 1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 12, 2'b00, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 12, 2'b01, 0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 16, 2'b01, 1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 12, 2'b00, 0};

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("reset_ce", 32'(cpu_ce), 32'd0);
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_step_cnt", step_cnt, 32'd0);
        reset = 1'b0;

        // Phase table: free-run, stall-dropped tick, single step, stalled step, run beats step
        for (int i = 0; i < 17; i++) begin
            run_sw    = vecs[i].run;
            step_btn  = vecs[i].step;
            cpu_stall = vecs[i].stall;
            base      = pulses;
            repeat (vecs[i].cycles) @(negedge clk_in);
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d_pulses", i), 32'(pulses - base), 32'(vecs[i].exp_pulses));
        end

`ifndef STEP_COUNT_EN
        chk("step_cnt_tied", step_cnt, 32'd0);
`endif

        // Short press (6 cycles) is filtered out
        base = pulses;
        step_btn = 1'b1;
        repeat (6) @(negedge clk_in);
        step_btn = 1'b0;
        repeat (20) @(negedge clk_in);
        chk("short_press_pulses", 32'(pulses - base), 32'd0);
        chk("short_press_state", 32'(state_o), 32'd0);

        // Bouncing press then held: exactly one pulse
        for (int i = 0; i < 5; i++) begin
            step_btn = ~step_btn;
            @(negedge clk_in);
        end
        step_btn = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("bounce_pulses", 32'(pulses - base), 32'd1);
        chk("bounce_state", 32'(state_o), 32'd0);
        step_btn = 1'b0;
        repeat (12) @(negedge clk_in);

        // Breakpoint at 0x10 after the 4th RUN pulse
        do_reset();
        base = pulses;
        bp_en = 1'b1;
        bp_addr = 32'h0000_0010;
        run_sw = 1'b1;
        wait_pulses("bp_four_pulses", base + 4, 200);
        chk("bp_pc_at_hit", cpu_pc, 32'h10);
        chk("bp_not_yet_halted", 32'(halted), 32'd0);
        @(negedge clk_in);
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_state", 32'(state_o), 32'd3);
        repeat (40) @(negedge clk_in);
        chk("bp_no_more_pulses", 32'(pulses - base), 32'd4);
        chk("bp_still_halted", 32'(halted), 32'd1);
        step_btn = 1'b1;
        wait_pulses("bp_step_pulse", base + 5, 30);
        chk("bp_step_pc", cpu_pc, 32'h14);
        chk("bp_step_state", 32'(state_o), 32'd0);
        chk("bp_step_halted", 32'(halted), 32'd0);
        run_sw = 1'b0;
        step_btn = 1'b0;
        bp_en = 1'b0;
        repeat (15) @(negedge clk_in);
        chk("bp_exit_state", 32'(state_o), 32'd0);

        // Asynchronous reset in the middle of a RUN pulse
        do_reset();
        run_sw = 1'b1;
        n = 0;
        while (cpu_ce !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        chk("midrun_ce_seen", 32'(cpu_ce), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrun_ce_drop", 32'(cpu_ce), 32'd0);
        chk("midrun_state", 32'(state_o), 32'd0);
        chk("midrun_halted", 32'(halted), 32'd0);
        run_sw = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        base = pulses;
        repeat (30) @(negedge clk_in);
        chk("post_reset_pulses", 32'(pulses - base), 32'd0);
        chk("post_reset_state", 32'(state_o), 32'd0);

`ifdef STEP_COUNT_EN
        do_reset();
        base = pulses;
        run_sw = 1'b1;
        wait_pulses("cnt_forty_pulses", base + 40, 700);
        chk("step_cnt_40", step_cnt, 32'd40);
        force dut.step_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.step_cnt_q;
        wait_pulses("cnt_wrap_pulse", base + 41, 30);
        chk("step_cnt_wrap", step_cnt, 32'd0);
        run_sw = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
